// File: rtl/qspi_psram_slave.sv
// QPI-mode PSRAM responder: decodes quad read/write transactions from a QSPI master and
// services them from a 4-bit wide, 131072-entry 1R1W nibble RAM. All bus pins are
// oversampled in the clk domain (clk must run at least 4x SCLK).
// Optional feature: define QSPI_READID_EN to accept command 8'h9F (read ID), which
// returns the nibble stream 0,D,5,D repeating after the usual address and dummy phases.
module qspi_psram_slave #(
    parameter int unsigned WAIT_CYCLES = 6,
    parameter logic [7:0]  CMD_READ    = 8'hEB,
    parameter logic [7:0]  CMD_WRITE   = 8'h38
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        qspi_sclk,
    input  logic        qspi_ce_n,
    input  logic [3:0]  qspi_sio_in,
    output logic [3:0]  qspi_sio_out,
    output logic        qspi_sio_oe,
    output logic [16:0] ram_radr,
    input  logic [3:0]  ram_rdata,
    output logic [16:0] ram_wadr,
    output logic [3:0]  ram_wdata,
    output logic        ram_wen
);

`ifdef QSPI_READID_EN
    localparam bit ReadIdEn = 1'b1;
`else
    localparam bit ReadIdEn = 1'b0;
`endif

    localparam logic [7:0] CmdReadId = 8'h9F;
    localparam logic [7:0] WaitCnt   = 8'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StWait, StRdata, StWdata, StIgnore
    } state_e;

    typedef enum logic [1:0] {ModeRead, ModeWrite, ModeId} mode_e;

    // Synchronisers; all pins share the same depth so samples stay aligned.
    logic [1:0] sclk_sync_q;
    logic [1:0] ce_sync_q;
    logic [7:0] sio_sync_q;
    logic       sclk_prev_q;

    logic       sclk_s, ce_s, rise, fall;
    logic [3:0] sio_s;

    state_e      state_q, state_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  cmd_q, cmd_d;
    // Only the low 12 address bits need keeping: with the final nibble they form addr[15:0].
    logic [11:0] addr_q, addr_d;
    logic [16:0] ptr_q, ptr_d;
    logic [3:0]  sio_out_q, sio_out_d;
    logic        sio_oe_q, sio_oe_d;
    logic [16:0] radr_q, radr_d;
    logic [16:0] wadr_q, wadr_d;
    logic [3:0]  wdata_q, wdata_d;
    logic        wen_q, wen_d;

    logic [7:0]  cmd_full;
    logic [3:0]  id_nib;
    logic        emit;

    assign sclk_s = sclk_sync_q[1];
    assign ce_s   = ce_sync_q[1];
    assign sio_s  = sio_sync_q[7:4];
    assign rise   = sclk_s & ~sclk_prev_q;
    assign fall   = ~sclk_s & sclk_prev_q;

    // Two-stage synchronisers plus the delayed SCLK used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= 2'b00;
            ce_sync_q   <= 2'b11;
            sio_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], qspi_sclk};
            ce_sync_q   <= {ce_sync_q[0], qspi_ce_n};
            sio_sync_q  <= {sio_sync_q[3:0], qspi_sio_in};
            sclk_prev_q <= sclk_sync_q[1];
        end
    end

    // Read-ID nibble stream 0,D,5,D indexed by the low pointer bits.
    always_comb begin
        id_nib = 4'h0;
        case (ptr_q[1:0])
            2'd0:    id_nib = 4'h0;
            2'd1:    id_nib = 4'hD;
            2'd2:    id_nib = 4'h5;
            default: id_nib = 4'hD;
        endcase
    end

    // Next-state and output decode for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        sio_out_d = sio_out_q;
        sio_oe_d  = sio_oe_q;
        radr_d    = radr_q;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        wen_d     = 1'b0;
        emit      = 1'b0;
        cmd_full  = {cmd_q, sio_s};

        if (ce_s) begin
            // Deselect discards any partial command or address.
            state_d  = StIdle;
            sio_oe_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StCmd;
                    cnt_d   = '0;
                end
                StCmd: begin
                    if (rise) begin
                        cmd_d = sio_s;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == 8'd1) begin
                            cnt_d   = '0;
                            state_d = StAddr;
                            if (cmd_full == CMD_READ) begin
                                mode_d = ModeRead;
                            end else if (cmd_full == CMD_WRITE) begin
                                mode_d = ModeWrite;
                            end else if (ReadIdEn && cmd_full == CmdReadId) begin
                                mode_d = ModeId;
                            end else begin
                                state_d = StIgnore;
                            end
                        end
                    end
                end
                StAddr: begin
                    if (rise) begin
                        addr_d = {addr_q[7:0], sio_s};
                        cnt_d  = cnt_q + 8'd1;
                        if (cnt_q == 8'd5) begin
                            cnt_d = '0;
                            if (mode_q == ModeId) begin
                                ptr_d   = '0;
                                state_d = StWait;
                            end else begin
                                ptr_d   = {addr_q[11:0], sio_s, 1'b0};
                                radr_d  = {addr_q[11:0], sio_s, 1'b0};
                                state_d = (mode_q == ModeWrite) ? StWdata : StWait;
                            end
                        end
                    end
                end
                StWait: begin
                    if (rise && cnt_q != WaitCnt) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    // The fall after the last dummy rise already carries the first nibble.
                    if (fall && cnt_q == WaitCnt) begin
                        emit    = 1'b1;
                        state_d = StRdata;
                    end
                end
                StRdata: begin
                    emit = fall;
                end
                StWdata: begin
                    if (rise) begin
                        wen_d   = 1'b1;
                        wadr_d  = ptr_q;
                        wdata_d = sio_s;
                        ptr_d   = ptr_q + 17'd1;
                    end
                end
                StIgnore: begin
                    sio_oe_d = 1'b0;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Present the current nibble and pre-fetch the next one before the next fall.
            if (emit) begin
                sio_oe_d = 1'b1;
                ptr_d    = ptr_q + 17'd1;
                if (mode_q == ModeId) begin
                    sio_out_d = id_nib;
                end else begin
                    sio_out_d = ram_rdata;
                    radr_d    = ptr_q + 17'd1;
                end
            end
        end
    end

    // State and registered outputs; reset applies immediately, dropping the output enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mode_q    <= ModeRead;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            ptr_q     <= '0;
            sio_out_q <= '0;
            sio_oe_q  <= 1'b0;
            radr_q    <= '0;
            wadr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ptr_q     <= ptr_d;
            sio_out_q <= sio_out_d;
            sio_oe_q  <= sio_oe_d;
            radr_q    <= radr_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            wen_q     <= wen_d;
        end
    end

    assign qspi_sio_out = sio_out_q;
    assign qspi_sio_oe  = sio_oe_q;
    assign ram_radr     = radr_q;
    assign ram_wadr     = wadr_q;
    assign ram_wdata    = wdata_q;
    assign ram_wen      = wen_q;

endmodule

// File: tb/tb_qspi_psram_slave.sv
// Scoreboard bench for qspi_psram_slave: a bus-master stimulus process pushes expected RAM
// writes and expected read nibbles into queues; independent monitors pop and compare.
module tb_qspi_psram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        qspi_sclk;
    logic        qspi_ce_n;
    logic [3:0]  qspi_sio_in;
    logic [3:0]  qspi_sio_out;
    logic        qspi_sio_oe;
    logic [16:0] ram_radr;
    logic [3:0]  ram_rdata;
    logic [16:0] ram_wadr;
    logic [3:0]  ram_wdata;
    logic        ram_wen;

    typedef struct packed {
        logic [16:0] a;
        logic [3:0]  d;
    } wr_exp_t;

    typedef struct packed {
        logic       oe;
        logic [3:0] d;
    } rd_exp_t;

    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t wr_e;
    rd_exp_t rd_e;

    logic [3:0] mem     [131072];
    logic [3:0] exp_mem [131072];
    logic       mem_init   = 1'b0;
    logic       rd_phase   = 1'b0;
    logic       oe_allowed = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qspi_psram_slave dut (
        .clk          (clk),
        .rst          (rst),
        .qspi_sclk    (qspi_sclk),
        .qspi_ce_n    (qspi_ce_n),
        .qspi_sio_in  (qspi_sio_in),
        .qspi_sio_out (qspi_sio_out),
        .qspi_sio_oe  (qspi_sio_oe),
        .ram_radr     (ram_radr),
        .ram_rdata    (ram_rdata),
        .ram_wadr     (ram_wadr),
        .ram_wdata    (ram_wdata),
        .ram_wen      (ram_wen)
    );

    // Nibble RAM with registered read address.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 131072; i++) mem[i] <= 4'(i * 7 + 3);
        end else if (ram_wen) begin
            mem[ram_wadr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_radr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
    endtask

    // Write monitor: every ram_wen cycle must match the next expected write.
    always @(negedge clk) begin
        if (ram_wen) begin
            if (wr_q.size() == 0) begin
                flag_unexpected("wr_unexpected", {15'd0, ram_wadr});
            end else begin
                wr_e = wr_q.pop_front();
                chk("wr_adr", {15'd0, ram_wadr}, {15'd0, wr_e.a});
                chk("wr_data", {28'd0, ram_wdata}, {28'd0, wr_e.d});
            end
        end
        if (!oe_allowed && !rst) chk("oe_idle", {31'd0, qspi_sio_oe}, 32'd0);
    end

    // Read monitor: the master samples SIO on each SCLK rise of the data phase.
    always @(posedge qspi_sclk) begin
        if (rd_phase) begin
            if (rd_q.size() == 0) begin
                flag_unexpected("rd_unexpected", {28'd0, qspi_sio_out});
            end else begin
                rd_e = rd_q.pop_front();
                chk("rd_oe", {31'd0, qspi_sio_oe}, {31'd0, rd_e.oe});
                if (rd_e.oe) chk("rd_data", {28'd0, qspi_sio_out}, {28'd0, rd_e.d});
            end
        end
    end

    task automatic clk_nib(input logic [3:0] d);
        qspi_sio_in = d;
        repeat (4) @(negedge clk);
        qspi_sclk = 1'b1;
        repeat (4) @(negedge clk);
        qspi_sclk = 1'b0;
    endtask

    task automatic send_nibs(input logic [23:0] v, input int n);
        for (int i = 0; i < n; i++) clk_nib(v[23-4*i -: 4]);
    endtask

    task automatic xfer_begin(input logic [7:0] cmd);
        qspi_ce_n = 1'b0;
        repeat (4) @(negedge clk);
        clk_nib(cmd[7:4]);
        clk_nib(cmd[3:0]);
    endtask

    task automatic xfer_end();
        qspi_sio_in = 4'h0;
        repeat (2) @(negedge clk);
        qspi_ce_n = 1'b1;
        repeat (8) @(negedge clk);
        rd_phase   = 1'b0;
        oe_allowed = 1'b0;
    endtask

    task automatic do_write(input logic [23:0] a, input logic [15:0] d, input int n);
        logic [16:0] p;
        logic [3:0]  nib;
        p = {a[15:0], 1'b0};
        xfer_begin(8'h38);
        send_nibs(a, 6);
        for (int i = 0; i < n; i++) begin
            nib = d[15-4*i -: 4];
            wr_q.push_back('{a: p, d: nib});
            exp_mem[p] = nib;
            p = p + 17'd1;
            clk_nib(nib);
        end
        xfer_end();
        chk("wr_drained", wr_q.size(), 0);
    endtask

    task automatic read_head(input logic [7:0] cmd, input logic [23:0] a);
        xfer_begin(cmd);
        send_nibs(a, 6);
        repeat (6) clk_nib(4'h0);
    endtask

    task automatic do_read(input logic [23:0] a, input int n);
        logic [16:0] p;
        p = {a[15:0], 1'b0};
        read_head(8'hEB, a);
        oe_allowed = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_q.push_back('{oe: 1'b1, d: exp_mem[p]});
            p = p + 17'd1;
        end
        rd_phase = 1'b1;
        repeat (n) clk_nib(4'h0);
        xfer_end();
        chk("rd_drained", rd_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        qspi_sclk   = 1'b0;
        qspi_ce_n   = 1'b1;
        qspi_sio_in = 4'h0;
        for (int i = 0; i < 131072; i++) exp_mem[i] = 4'(i * 7 + 3);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_oe", {31'd0, qspi_sio_oe}, 32'd0);
        chk("rst_sio_out", {28'd0, qspi_sio_out}, 32'd0);
        chk("rst_wen", {31'd0, ram_wen}, 32'd0);
        chk("rst_radr", {15'd0, ram_radr}, 32'd0);
        chk("rst_wadr", {15'd0, ram_wadr}, 32'd0);
        chk("rst_wdata", {28'd0, ram_wdata}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write then read back; upper address byte is ignored.
        do_write(24'h000010, 16'h1234, 4);
        do_read(24'h000010, 4);
        do_read(24'hFF0010, 4);

        // Pointer wrap on write and read.
        do_write(24'h00FFFF, 16'hABCD, 4);
        do_read(24'h00FFFF, 4);

        // Abort after 3 address nibbles, then a full read of address 0.
        xfer_begin(8'hEB);
        send_nibs(24'h000000, 3);
        xfer_end();
        do_read(24'h000000, 4);

        // Unknown command: bus is ignored, then normal decode resumes.
        xfer_begin(8'h05);
        for (int i = 0; i < 10; i++) clk_nib(4'(i + 5));
        xfer_end();
        do_write(24'h000100, 16'h5A3C, 4);
        do_read(24'h000100, 4);

        // Reset during the data phase of a read.
        read_head(8'hEB, 24'h000010);
        oe_allowed = 1'b1;
        rd_q.push_back('{oe: 1'b1, d: exp_mem[17'h20]});
        rd_q.push_back('{oe: 1'b1, d: exp_mem[17'h21]});
        rd_phase = 1'b1;
        repeat (2) clk_nib(4'h0);
        rd_phase = 1'b0;
        chk("rd_drained", rd_q.size(), 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_oe", {31'd0, qspi_sio_oe}, 32'd0);
        chk("arst_sio_out", {28'd0, qspi_sio_out}, 32'd0);
        chk("arst_radr", {15'd0, ram_radr}, 32'd0);
        chk("arst_wadr", {15'd0, ram_wadr}, 32'd0);
        chk("arst_wdata", {28'd0, ram_wdata}, 32'd0);
        chk("arst_wen", {31'd0, ram_wen}, 32'd0);
        qspi_ce_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        oe_allowed = 1'b0;
        repeat (4) @(negedge clk);
        do_read(24'h000010, 4);

        // Read-ID command.
        read_head(8'h9F, 24'h123456);
`ifdef QSPI_READID_EN
        oe_allowed = 1'b1;
        rd_q.push_back('{oe: 1'b1, d: 4'h0});
        rd_q.push_back('{oe: 1'b1, d: 4'hD});
        rd_q.push_back('{oe: 1'b1, d: 4'h5});
        rd_q.push_back('{oe: 1'b1, d: 4'hD});
        rd_q.push_back('{oe: 1'b1, d: 4'h0});
        rd_q.push_back('{oe: 1'b1, d: 4'hD});
`else
        for (int i = 0; i < 6; i++) rd_q.push_back('{oe: 1'b0, d: 4'h0});
`endif
        rd_phase = 1'b1;
        repeat (6) clk_nib(4'h0);
        xfer_end();
        chk("rd_drained", rd_q.size(), 0);

        chk("wr_final_empty", wr_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qspi_psram_slave.md
Name: qspi_psram_slave

Overview:
- QPI-mode PSRAM responder that decodes QSPI bus transactions from the CPU's QSPI master.
- Services quad read and quad write by driving the 4-bit-wide 131072-entry 1R1W nibble RAM (64 KB) through its read and write ports.
- All bus pins are oversampled in the system clock domain. Used as the simulation/FPGA memory model behind the QSPI controller.

Parameters:
- WAIT_CYCLES, 6, number of dummy SCLK rising edges between the last address nibble and the first read data nibble.
- CMD_READ, 8'hEB, quad read command code.
- CMD_WRITE, 8'h38, quad write command code.

Ports:
- clk  input  1  system clock; must be at least 4x SCLK frequency.
- rst  input  1  asynchronous active-high reset.
- qspi_sclk  input  1  QSPI serial clock from the master; asynchronous.
- qspi_ce_n  input  1  chip enable, active low; asynchronous.
- qspi_sio_in  input  4  SIO[3:0] from the master.
- qspi_sio_out  output  4  SIO[3:0] driven to the master.
- qspi_sio_oe  output  1  output enable for qspi_sio_out.
- ram_radr  output  17  nibble read address to the RAM; RAM registers it, so data is valid one clk later.
- ram_rdata  input  4  nibble read data from the RAM.
- ram_wadr  output  17  nibble write address.
- ram_wdata  output  4  nibble write data.
- ram_wen  output  1  write strobe, one clk per nibble.

Behaviour:
- Synchronisation:
  - qspi_sclk, qspi_ce_n and qspi_sio_in pass through 2-flop synchronisers, all on the same stage count so they stay aligned.
  - Rise event: synced SCLK is 1 now and was 0 last clk. Fall event: the reverse.
- Reset: state=IDLE; qspi_sio_out=0, qspi_sio_oe=0, ram_wen=0, ram_radr=0, ram_wadr=0, ram_wdata=0; nibble pointer, command and counters cleared.
- Bus format:
  - QPI only. Command is 2 nibbles, then address is 6 nibbles (24-bit byte address), MSB-first on every rise event.
  - Byte address bits [23:16] are ignored.
  - Nibble pointer = {addr[15:0],1'b0}: high nibble of each byte comes first.
  - Pointer increments by 1 per data nibble and wraps 17'h1FFFF -> 0.
- States:
  - IDLE: waits for synced ce_n=0, then goes to CMD with the nibble counter at 0.
  - CMD: shifts in 2 nibbles. After the 2nd rise, goes to ADDR if the code matches CMD_READ or CMD_WRITE, otherwise to IGNORE.
  - ADDR: shifts in 6 nibbles. After the 6th rise, loads the pointer, drives ram_radr=pointer, and goes to WAIT (read) or WDATA (write).
  - WAIT: counts WAIT_CYCLES rise events. On the fall event following the last of them, goes to RDATA.
  - RDATA:
    - Each fall event sets qspi_sio_out=ram_rdata and qspi_sio_oe=1.
    - Pointer and ram_radr increment in the same clk, so the next nibble is valid before the next fall event.
    - The first nibble output is the one at the loaded pointer.
  - WDATA:
    - Each rise event gives a one-clk pulse: ram_wen=1, ram_wadr=pointer, ram_wdata=synced sio_in.
    - Pointer increments on the same clk.
  - IGNORE: qspi_sio_oe=0; ignores the bus until ce_n goes high.
- ce_n high (synced) in any state:
  - Next clk: state=IDLE, qspi_sio_oe=0, ram_wen=0. Any partial command or address is discarded.
  - Nibbles already written stay written.
- ce_n with no SCLK activity: the block stays in its current state with no RAM access.
- Unbounded bursts are allowed in both directions; pointer wraps as specified.
- Async rst mid-transaction: immediately applies the reset values. qspi_sio_oe drops without waiting for a clock.
- A write never overlaps a read. ram_radr is driven only in ADDR/RDATA and holds its value otherwise.

Optional Feature:
- Macro QSPI_READID_EN.
- Defined:
  - Command 8'h9F is also accepted.
  - It takes 6 address nibbles (values ignored), then WAIT_CYCLES dummy rises.
  - It then outputs the nibble sequence 0,D,5,D repeating (MFID 8'h0D, KGD 8'h5D) until ce_n high, with the same fall-event timing as RDATA.
  - No RAM access.
- Undefined: 8'h9F is treated as an unknown command and goes to IGNORE.

Test Plan:
- Write then read back: write EB-free burst cmd 38, addr 24'h000010, data nibbles 1,2,3,4 -> ram_wen pulses 4 times at wadr 17'h20..17'h23; then cmd EB, addr 24'h000010, 6 dummies -> sio_out 1,2,3,4 on successive fall events, sio_oe=1 from the first data fall.
- Wrap-around: write cmd 38, addr 24'h00FFFF, 4 nibbles A,B,C,D -> wadr 17'h1FFFE, 17'h1FFFF, 0, 1.
- Abort: raise ce_n after 3 address nibbles of cmd EB -> no RAM access, sio_oe stays 0, state IDLE. A following full read of addr 0 returns the correct data.
- Unknown command 8'h05 followed by 10 SCLK cycles -> sio_oe=0 and ram_wen=0 throughout; the next transaction after ce_n high decodes normally.
- Reset mid-read: assert rst during RDATA -> sio_oe=0 asynchronously, all outputs at reset values. The next read works.
- With QSPI_READID_EN: cmd 9F, 6 address nibbles, 6 dummies -> sio_out 0,D,5,D,0,D. Without the macro, the same stimulus gives sio_oe=0 throughout.
